// File: rtl/vco_band_cal.sv
// Coarse VCO band calibration: 5-bit binary search on tune using a refclk-timed edge count.
// Define VCO_BAND_CAL_RANGE_EN to flag results pinned at either end of the tune range.
module vco_band_cal #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned SETTLE = 16
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        vco_div,
    input  logic [15:0] target_cnt,
    output logic [4:0]  tune,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCount,
        StDecide,
        StDone
    } state_e;

    state_e        r_state;
    logic [4:0]    r_tune;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_count;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;

    logic          w_edge;
    logic          w_keep;
    logic [4:0]    w_tune_next;
    logic          w_range_err;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= vco_div;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;
    assign w_keep = (r_count < target_cnt);

    always_comb begin
        w_tune_next = r_tune;
        if (!w_keep) begin
            w_tune_next[r_idx] = 1'b0;
        end
        if (r_idx != 3'd0) begin
            w_tune_next[r_idx - 3'd1] = 1'b1;
        end
    end

`ifdef VCO_BAND_CAL_RANGE_EN
    // Only meaningful on the last decision, where w_tune_next is the final code.
    assign w_range_err = ((w_tune_next == 5'b00000) && !w_keep) ||
                         ((w_tune_next == 5'b11111) && w_keep);
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_tune  <= 5'b01111;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= 3'd0;
            r_timer <= '0;
            r_count <= 16'd0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StSettle;
                        r_tune  <= 5'b10000;
                        r_idx   <= 3'd4;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_timer <= '0;
                    end
                end
                StSettle: begin
                    if (r_timer == SETTLE_LAST) begin
                        r_timer <= '0;
                        r_count <= 16'd0;
                        r_state <= StCount;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StCount: begin
                    if (w_edge && (r_count != 16'hFFFF)) begin
                        r_count <= r_count + 16'd1;
                    end
                    if (r_timer == WINDOW_LAST) begin
                        r_timer <= '0;
                        r_state <= StDecide;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StDecide: begin
                    r_tune <= w_tune_next;
                    if (r_idx != 3'd0) begin
                        r_idx   <= r_idx - 3'd1;
                        r_state <= StSettle;
                    end else begin
                        // r_count is left untouched so it holds the final count in DONE.
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= w_range_err;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tune = r_tune;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_vco_band_cal.sv
// Directed bench for vco_band_cal with a phase-accumulator VCO giving 8*tune edges per window.
module tb_vco_band_cal;

    // Window widened so the 8*tune model (up to 248 edges) stays below refclk/4.
    localparam int unsigned WIN     = 1024;
    localparam int unsigned SET     = 16;
    localparam int          CAL_CYC = 1 + 5 * (SET + WIN + 1);
    localparam int          LIMIT   = CAL_CYC + 200;

`ifdef VCO_BAND_CAL_RANGE_EN
    localparam logic RANGE_ERR = 1'b1;
`else
    localparam logic RANGE_ERR = 1'b0;
`endif

    logic        refclk;
    logic        rst_n;
    logic        start;
    logic        vco_div;
    logic [15:0] target_cnt;
    logic [4:0]  tune;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp;
    int n_fail;

    logic [9:0]  phase;
    logic [4:0]  trials [8];
    int          n_trials;
    logic        first_busy;
    logic        first_done;
    logic        first_err;

    vco_band_cal #(
        .WINDOW(WIN),
        .SETTLE(SET)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .start     (start),
        .vco_div   (vco_div),
        .target_cnt(target_cnt),
        .tune      (tune),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Phase wraps 8*tune times per 1024 refclk cycles; MSB is the divided VCO output.
    always @(negedge refclk) phase <= phase + {2'b00, tune, 3'b000};
    assign vco_div = phase[9];

    task automatic run_cal(input logic [15:0] tgt, input int poke_at, output int cycles);
        target_cnt = tgt;
        start = 1'b1;
        @(posedge refclk);
        #1;
        start = 1'b0;
        cycles = 1;
        first_busy = busy;
        first_done = done;
        first_err  = err;
        trials[0] = tune;
        n_trials = 1;
        while (!done && cycles < LIMIT) begin
            start = (cycles == poke_at);
            @(posedge refclk);
            #1;
            cycles++;
            if (busy && n_trials < 8 && tune !== trials[n_trials - 1]) begin
                trials[n_trials] = tune;
                n_trials++;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string name, input int cycles,
                                input logic [4:0] exp_tune, input logic exp_err);
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: done never rose within %0d cycles", name, LIMIT);
        end
        n_cmp++;
        if (cycles !== CAL_CYC) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cycles, CAL_CYC);
        end
        n_cmp++;
        if (tune !== exp_tune) begin
            n_fail++;
            $display("FAIL %s tune: got %b, want %b", name, tune, exp_tune);
        end
        n_cmp++;
        if ({busy, err} !== {1'b0, exp_err}) begin
            n_fail++;
            $display("FAIL %s busy/err: got %b%b, want 0%b", name, busy, err, exp_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        n_cmp++;
        if ({tune, busy, done, err} !== 8'b01111_000) begin
            n_fail++;
            $display("FAIL reset_held: got %b, want 01111000", {tune, busy, done, err});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge refclk);
            #1;
            n_cmp++;
            if ({tune, busy, done, err} !== 8'b01111_000) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b, want 01111000", i,
                         {tune, busy, done, err});
            end
        end
    endtask

    task automatic test_nominal;
        int cyc;
        logic [4:0] exp_tr [5];
        exp_tr = '{5'b10000, 5'b01000, 5'b01100, 5'b01110, 5'b01101};
        run_cal(16'd100, 0, cyc);
        n_cmp++;
        if ({first_busy, first_done, first_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL nominal_accept busy/done/err: got %b, want 100",
                     {first_busy, first_done, first_err});
        end
        n_cmp++;
        if (n_trials !== 5) begin
            n_fail++;
            $display("FAIL nominal_trial_count: got %0d, want 5", n_trials);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (trials[i] !== exp_tr[i]) begin
                n_fail++;
                $display("FAIL nominal_trial%0d: got %b, want %b", i, trials[i], exp_tr[i]);
            end
        end
        check_result("nominal", cyc, 5'b01100, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc;
        // 16->128 keep, 24->192 keep, 28->224 clear, 26->208 clear, 25->200 equal clears.
        run_cal(16'd200, 0, cyc);
        n_cmp++;
        if ({first_busy, first_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_done_drop busy/done: got %b, want 10", {first_busy, first_done});
        end
        check_result("b2b", cyc, 5'b11000, 1'b0);
    endtask

    task automatic test_start_mid_count;
        int cyc;
        run_cal(16'd100, SET + 500, cyc);
        check_result("start_ignored", cyc, 5'b01100, 1'b0);
    endtask

    task automatic test_reset_mid_count;
        int cyc;
        target_cnt = 16'd100;
        start = 1'b1;
        @(posedge refclk);
        #1;
        start = 1'b0;
        repeat (SET + 300) @(posedge refclk);
        #4;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tune, busy, done, err} !== 8'b01111_000) begin
            n_fail++;
            $display("FAIL reset_async: got %b, want 01111000", {tune, busy, done, err});
        end
        repeat (2) @(posedge refclk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge refclk);
        #1;
        n_cmp++;
        if ({tune, busy, done, err} !== 8'b01111_000) begin
            n_fail++;
            $display("FAIL reset_no_resume: got %b, want 01111000", {tune, busy, done, err});
        end
        run_cal(16'd100, 0, cyc);
        check_result("after_reset", cyc, 5'b01100, 1'b0);
    endtask

    task automatic test_saturate_high;
        int cyc;
        run_cal(16'hFFFF, 0, cyc);
        check_result("target_max", cyc, 5'b11111, RANGE_ERR);
    endtask

    task automatic test_zero_target;
        int cyc;
        run_cal(16'd0, 0, cyc);
        n_cmp++;
        if (first_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_err_clear: got %b, want 0", first_err);
        end
        check_result("target_zero", cyc, 5'b00000, RANGE_ERR);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        phase = 10'd0;
        start = 1'b0;
        target_cnt = 16'd0;
        rst_n = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_start_mid_count();
        test_reset_mid_count();
        test_saturate_high();
        test_zero_target();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
